// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - two-requester arbiter with lock in front of a single-port bypass RAM
// Optional feature macro: SP_ARB_FIXED_PRIO_EN (fixed priority, port A wins ties)
module sp_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t r_state;
  logic   r_a_rvalid;
  logic   r_b_rvalid;
  logic   w_a_gnt;
  logic   w_b_gnt;
  logic   w_tie_a;

`ifdef SP_ARB_FIXED_PRIO_EN
  assign w_tie_a = 1'b1;
`else
  logic r_last_b;

  // Round-robin memory: remembers which port was granted most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_a_gnt) begin
      r_last_b <= 1'b0;
    end else if (w_b_gnt) begin
      r_last_b <= 1'b1;
    end
  end

  assign w_tie_a = r_last_b;
`endif

  // Grant decision: owner-only while locked, otherwise single requester or tie-break
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_OWN_A: w_a_gnt = a_req;
        ST_OWN_B: w_b_gnt = b_req;
        default: begin
          if (a_req && b_req) begin
            w_a_gnt = w_tie_a;
            w_b_gnt = !w_tie_a;
          end else begin
            w_a_gnt = a_req;
            w_b_gnt = b_req;
          end
        end
      endcase
    end
  end

  // Lock FSM plus read-valid pulses one cycle after each granted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_gnt && !a_we;
      r_b_rvalid <= w_b_gnt && !b_we;
      case (r_state)
        ST_OWN_A: if (!a_lock) r_state <= ST_IDLE;
        ST_OWN_B: if (!b_lock) r_state <= ST_IDLE;
        default: begin
          if (w_a_gnt && a_lock) begin
            r_state <= ST_OWN_A;
          end else if (w_b_gnt && b_lock) begin
            r_state <= ST_OWN_B;
          end
        end
      endcase
    end
  end

  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = ram_dout;
  assign b_rdata   = ram_dout;

  assign ram_ce    = w_a_gnt | w_b_gnt;
  assign ram_wre   = (w_a_gnt & a_we) | (w_b_gnt & b_we);
  assign ram_ad    = w_b_gnt ? b_addr : a_addr;
  assign ram_din   = w_b_gnt ? b_wdata : a_wdata;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - self-checking bench for sp_ram_arbiter with behavioural model
module tb_sp_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [8:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_ce, ram_oce, ram_wre, ram_reset;
  logic [8:0] ram_ad;
  logic [7:0] ram_din, ram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  sp_ram_arbiter #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_reset(ram_reset),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read
  logic [7:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
      else         ram_dout <= ram_mem[ram_ad];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner (-1 none, 0 A, 1 B), last granted port, memory image
  int         m_owner = -1;
  int         m_last  = 1;
  logic [7:0] m_mem [512];
  bit [511:0] m_valid = '0;
  bit         m_pa = 0, m_pb = 0, m_pd_ok = 0;
  logic [7:0] m_pd;
  bit         ea, eb;
  int         g;
  logic       g_we;
  logic [8:0] g_addr;
  logic [7:0] g_wdata;

  always @(negedge clk) begin
    chk("ram_oce", ram_oce, 1);
    chk("ram_reset", ram_reset, 0);
    if (!rst_n) begin
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_ram_ce", ram_ce, 0);
      chk("rst_ram_wre", ram_wre, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      m_owner = -1;
      m_last  = 1;
      m_pa = 0;
      m_pb = 0;
    end else begin
      ea = 0;
      eb = 0;
      if (m_owner == 0) ea = a_req;
      else if (m_owner == 1) eb = b_req;
      else if (a_req && b_req) begin
`ifdef SP_ARB_FIXED_PRIO_EN
        ea = 1;
`else
        if (m_last == 1) ea = 1; else eb = 1;
`endif
      end else begin
        ea = a_req;
        eb = b_req;
      end
      chk("a_gnt", a_gnt, ea);
      chk("b_gnt", b_gnt, eb);
      chk("ram_ce", ram_ce, ea | eb);
      g       = eb ? 1 : 0;
      g_we    = eb ? b_we : a_we;
      g_addr  = eb ? b_addr : a_addr;
      g_wdata = eb ? b_wdata : a_wdata;
      chk("ram_wre", ram_wre, (ea | eb) & g_we);
      if (ea | eb) begin
        chk("ram_ad", ram_ad, g_addr);
        if (g_we) chk("ram_din", ram_din, g_wdata);
      end
      chk("a_rvalid", a_rvalid, m_pa);
      chk("b_rvalid", b_rvalid, m_pb);
      if ((m_pa || m_pb) && m_pd_ok) begin
        chk("a_rdata", a_rdata, m_pd);
        chk("b_rdata", b_rdata, m_pd);
      end
      m_pa = ea && !a_we;
      m_pb = eb && !b_we;
      if (ea | eb) begin
        if (g_we) begin
          m_mem[g_addr]   = g_wdata;
          m_valid[g_addr] = 1'b1;
        end else begin
          m_pd    = m_mem[g_addr];
          m_pd_ok = m_valid[g_addr];
        end
        m_last = g;
        if (m_owner < 0 && (g == 0 ? a_lock : b_lock)) m_owner = g;
      end
      if (m_owner == 0 && !a_lock) m_owner = -1;
      else if (m_owner == 1 && !b_lock) m_owner = -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  function automatic logic [8:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 9'h1FF;
    return 9'($urandom_range(0, 15));
  endfunction

  logic [3:0] lit_ga, lit_gb;
  logic [4:0] lit_rva, lit_rvb;
  bit         ga, gb;
  int         wa, wb, max_wait;

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    tick();

    // Both ports read for four cycles from the reset tie-break state
`ifdef SP_ARB_FIXED_PRIO_EN
    lit_ga = 4'b1111; lit_gb = 4'b0000; lit_rva = 5'b11110; lit_rvb = 5'b00000;
`else
    lit_ga = 4'b0101; lit_gb = 4'b1010; lit_rva = 5'b01010; lit_rvb = 5'b10100;
`endif
    a_req = 1; b_req = 1; a_addr = 9'd3; b_addr = 9'd5;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin a_req = 0; b_req = 0; end
      @(negedge clk);
      if (k < 4) begin
        chk("tie_a_gnt", a_gnt, lit_ga[k]);
        chk("tie_b_gnt", b_gnt, lit_gb[k]);
      end
      if (k > 0) begin
        chk("tie_a_rvalid", a_rvalid, lit_rva[k]);
        chk("tie_b_rvalid", b_rvalid, lit_rvb[k]);
      end
      tick();
    end

    // B alone is granted immediately (fixed priority: only when A idle)
    b_req = 1; b_addr = 9'd7;
    @(negedge clk);
    chk("solo_b_gnt", b_gnt, 1);
    tick();

    // A writes 0x5A to 0x1FF, B reads it back the following cycle
    b_req = 0;
    a_req = 1; a_we = 1; a_addr = 9'h1FF; a_wdata = 8'h5A;
    @(negedge clk);
    chk("wr_a_gnt", a_gnt, 1);
    tick();
    a_req = 0; a_we = 0;
    b_req = 1; b_we = 0; b_addr = 9'h1FF;
    @(negedge clk);
    chk("rd_b_gnt", b_gnt, 1);
    tick();
    b_req = 0;
    @(negedge clk);
    chk("raw_b_rvalid", b_rvalid, 1);
    chk("raw_b_rdata", b_rdata, 8'h5A);
    chk("raw_a_rvalid", a_rvalid, 0);
    tick();

    // A locks ownership for three cycles while B keeps requesting
    a_req = 1; a_lock = 1; a_addr = 9'd2;
    b_req = 1; b_addr = 9'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_a_gnt", a_gnt, 1);
      chk("lock_b_gnt", b_gnt, 0);
      tick();
    end
    a_req = 0; a_lock = 0;
    @(negedge clk);
    chk("unlock_b_stall", b_gnt, 0);
    tick();
    @(negedge clk);
    chk("unlock_b_gnt", b_gnt, 1);
    tick();
    b_req = 0;

    // Reset asserted right after a read grant: no stray rvalid
    a_req = 1; a_addr = 9'd1;
    @(negedge clk);
    chk("prerst_a_gnt", a_gnt, 1);
    tick();
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("inrst_a_gnt", a_gnt, 0);
      chk("inrst_ram_ce", ram_ce, 0);
      chk("inrst_a_rvalid", a_rvalid, 0);
      tick();
    end
    rst_n = 1; a_req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("postrst_a_rvalid", a_rvalid, 0);
      tick();
    end

    // Randomized traffic; requesters hold their access until granted
    wa = 0; wb = 0; max_wait = 0; ga = 0; gb = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (!a_req || ga) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
        a_addr = rand_addr(); a_wdata = 8'($urandom);
      end
      if (!b_req || gb) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
        b_addr = rand_addr(); b_wdata = 8'($urandom);
      end
      a_lock = ($urandom_range(0, 3) == 0);
      b_lock = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      ga = a_gnt; gb = b_gnt;
      if (a_req && !ga && rst_n) wa++; else wa = 0;
      if (b_req && !gb && rst_n) wb++; else wb = 0;
      if (wa > max_wait) max_wait = wa;
      if (wb > max_wait) max_wait = wb;
      tick();
    end
    chk("max_stall_le_200", max_wait <= 200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, per requester p in {a,b}: p_req input 1 (access request), p_we input 1 (1=write, 0=read), p_lock input 1 (keep ownership after grant), p_addr input ADDR_W, p_wdata input DATA_W.
REQ-006 SHALL have, per requester p: p_gnt output 1 (request accepted this cycle), p_rvalid output 1 (read data valid), p_rdata output DATA_W.
REQ-007 SHALL have RAM-side ports: ram_ce output 1, ram_oce output 1, ram_wre output 1, ram_reset output 1, ram_ad output ADDR_W, ram_din output DATA_W, ram_dout input DATA_W (bypass-mode RAM, 1-cycle read latency).

Function
REQ-008 SHALL accept at most one access per cycle; p_gnt is combinational from p_req and arbiter state, and at most one gnt is high per cycle.
REQ-009 Requester SHALL hold p_req, p_we, p_addr, p_wdata stable until p_gnt; the access completes in the gnt cycle.
REQ-010 In the gnt cycle SHALL drive ram_ce=1, ram_wre=p_we, ram_ad=p_addr, ram_din=p_wdata of the granted port; ram_ce=0 and ram_wre=0 when no grant.
REQ-011 ram_oce SHALL be tied 1 and ram_reset tied 0.
REQ-012 Default arbitration SHALL be round-robin: state LAST in {A,B}; when both request, grant the port not equal to LAST; LAST updates to granted port on every grant.
REQ-013 Single requester SHALL be granted immediately regardless of LAST.
REQ-014 Lock: FSM states IDLE, OWN_A, OWN_B; grant with p_lock=1 moves IDLE->OWN_p; in OWN_p only port p can be granted; exit to IDLE on the first cycle p_lock=0 (grants in that cycle still follow OWN_p).
REQ-015 In OWN_p, a request from the other port SHALL stall (gnt=0) indefinitely until lock release; no timeout.
REQ-016 For a granted read, p_rvalid SHALL pulse high exactly one cycle after gnt with p_rdata=ram_dout in that cycle; writes never raise rvalid.
REQ-017 p_rdata SHALL be ram_dout wired to both ports; only the owning port's rvalid rises.
REQ-018 Back-to-back reads SHALL sustain one access per cycle with one rvalid per read, in grant order.
REQ-019 Write then read of same address in consecutive cycles SHALL return the new data.

Reset
REQ-020 On rst_n=0, asynchronously: FSM=IDLE, LAST=B (so port A wins first tie), a_rvalid=b_rvalid=0.
REQ-021 During reset all gnt outputs, ram_ce and ram_wre SHALL be 0.
REQ-022 A read granted in the cycle before reset assertion SHALL NOT produce rvalid after reset release.
REQ-023 After rst_n deasserts, the first rising edge SHALL be able to grant.

Configuration
REQ-024 Macro SP_ARB_FIXED_PRIO_EN: when defined, round-robin is replaced by fixed priority (port A always wins ties; LAST unused); lock behaviour unchanged.
REQ-025 When SP_ARB_FIXED_PRIO_EN is undefined, REQ-012 round-robin applies.

Verification
REQ-026 After reset, a_req=b_req=1 reads held 4 cycles -> gnt sequence A,B,A,B; rvalid on matching port one cycle after each gnt.
REQ-027 a writes 0x5A to addr 0x1FF, next cycle b reads 0x1FF -> b_rvalid next cycle with b_rdata=0x5A, a_rvalid stays 0.
REQ-028 a_lock=1 with a_req for 3 cycles while b_req=1 -> a granted 3 times, b_gnt=0; a_lock drops -> b granted next cycle.
REQ-029 rst_n pulsed low the cycle after a read grant -> gnt=0, ram_ce=0 during reset, no rvalid after release.
REQ-030 With SP_ARB_FIXED_PRIO_EN defined, both requesting 4 cycles -> gnt A,A,A,A; b granted only when a_req=0.
